// File: rtl/mul_result_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_result_buffer_pkg
// Purpose  : Shared constants and the FIFO entry layout for the multiplier
//            result buffer.
// Contents : c_DATA_WIDTH / c_DEPTH / c_MUL_LAT defaults, res_entry_t
//            ({product, ovf}) and the entry_width() helper.
// Revision : 1.0  initial release
// ============================================================================
package mul_result_buffer_pkg;

  localparam int c_DATA_WIDTH = 32;
  localparam int c_DEPTH      = 4;
  localparam int c_MUL_LAT    = 2;

  // One buffered result: full-width product with the overflow flag in the LSB.
  typedef struct packed {
    logic [2*c_DATA_WIDTH-1:0] product;
    logic                      ovf;
  } res_entry_t;

  // Width of a packed {product, ovf} entry for an arbitrary operand width.
  function automatic int entry_width(input int data_width);
    return 2 * data_width + 1;
  endfunction

endpackage : mul_result_buffer_pkg
`default_nettype wire

// File: rtl/mul_res_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mul_res_fifo
// Purpose  : Synchronous FIFO with occupancy count. Storage is not reset;
//            only pointers and count are.
// Ports    : clk, rst        clock, asynchronous active-high reset
//            wr_en_i/wr_data_i  push an entry at the tail
//            rd_en_i         pop the head (ignored when empty)
//            rd_data_o       head entry (stable until popped)
//            valid_o         head entry present
//            count_o         number of stored entries, 0..DEPTH
// Revision : 1.0  initial release
// ============================================================================
module mul_res_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic             push, pop;

  assign push = wr_en_i;
  assign pop  = rd_en_i & (count_q != '0);

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data array carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign valid_o   = (count_q != '0);
  assign count_o   = count_q;

endmodule : mul_res_fifo
`default_nettype wire

// File: rtl/mul_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : mul_result_buffer
// Purpose  : Issues operand pairs to a fixed-latency, non-stallable
//            multiplier and buffers the products in order. A slot is
//            reserved for every issued op so a capture never finds the FIFO
//            full.
// Ports    : clk, rst                  clock, asynchronous active-high reset
//            req_valid_i/req_ready_o   operand handshake
//            req_op1_i/req_op2_i       operands
//            mul_en_o, mul_op1/2_o     multiplier issue
//            mul_res_i/mul_ovf_i       multiplier result, MUL_LAT after issue
//            out_valid_o/out_ready_i   result handshake
//            out_data_o/out_ovf_o      head product and overflow flag
// Revision : 1.0  initial release
// ============================================================================
module mul_result_buffer
  import mul_result_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH,
  parameter int DEPTH      = c_DEPTH,
  parameter int MUL_LAT    = c_MUL_LAT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid_i,
  input  logic [DATA_WIDTH-1:0]   req_op1_i,
  input  logic [DATA_WIDTH-1:0]   req_op2_i,
  output logic                    req_ready_o,
  output logic                    mul_en_o,
  output logic [DATA_WIDTH-1:0]   mul_op1_o,
  output logic [DATA_WIDTH-1:0]   mul_op2_o,
  input  logic [2*DATA_WIDTH-1:0] mul_res_i,
  input  logic                    mul_ovf_i,
  output logic                    out_valid_o,
  output logic [2*DATA_WIDTH-1:0] out_data_o,
  output logic                    out_ovf_o,
  input  logic                    out_ready_i
);

  localparam int ENTRY_W = entry_width(DATA_WIDTH);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int INF_W   = $clog2(MUL_LAT + 1);

  logic                 accept;
  logic                 capture;
  logic                 pop;
  logic [MUL_LAT-1:0]   pipe_q, pipe_d;
  logic [INF_W-1:0]     inflight;
  logic [31:0]          occupancy;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_valid;
  logic [ENTRY_W-1:0]   wr_entry;
  logic [ENTRY_W-1:0]   rd_entry;

  // ---------------------------------------------------------------- issue
  assign accept    = req_valid_i & req_ready_o;
  assign mul_en_o  = accept;
  assign mul_op1_o = req_op1_i;
  assign mul_op2_o = req_op2_i;

  // Issue pipe tracks which in-flight cycles carry a real op.
  if (MUL_LAT == 1) begin : g_pipe_single
    assign pipe_d = accept;
  end else begin : g_pipe_shift
    assign pipe_d = {pipe_q[MUL_LAT-2:0], accept};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pipe_q <= '0;
    else     pipe_q <= pipe_d;
  end

  assign capture = pipe_q[MUL_LAT-1];

  // ---------------------------------------------------------------- credit
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MUL_LAT; i++) begin
      inflight = inflight + INF_W'(pipe_q[i]);
    end
  end

  // Buffered results plus ops still in the multiplier must fit the FIFO.
  // Only registered state (and reset) feeds this, never the handshakes.
  assign occupancy   = 32'(fifo_count) + 32'(inflight);
  assign req_ready_o = ~rst & (occupancy < 32'(DEPTH));

  // ---------------------------------------------------------------- buffer
  // Entry layout matches res_entry_t: product above, ovf in bit 0.
  assign wr_entry = {mul_res_i, mul_ovf_i};
  assign pop      = fifo_valid & out_ready_i;

  mul_res_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (capture),
    .wr_data_i (wr_entry),
    .rd_en_i   (pop),
    .rd_data_o (rd_entry),
    .valid_o   (fifo_valid),
    .count_o   (fifo_count)
  );

  assign out_valid_o = fifo_valid;
  assign out_data_o  = rd_entry[ENTRY_W-1:1];
  assign out_ovf_o   = rd_entry[0];

endmodule : mul_result_buffer
`default_nettype wire

// File: tb/tb_mul_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_result_buffer
// Purpose  : Directed self-checking bench for mul_result_buffer with a
//            two-stage multiplier model and a throttled scoreboard phase.
// Revision : 1.0  initial release
// ============================================================================
module tb_mul_result_buffer;
  import mul_result_buffer_pkg::*;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [DW-1:0] req_op1, req_op2;
  logic          req_ready;
  logic          mul_en;
  logic [DW-1:0] mul_op1, mul_op2;
  logic [2*DW-1:0] mul_res;
  logic          mul_ovf;
  logic          out_valid;
  logic [2*DW-1:0] out_data;
  logic          out_ovf;
  logic          out_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul_result_buffer #(.DATA_WIDTH(DW), .DEPTH(4), .MUL_LAT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_op1_i   (req_op1),
    .req_op2_i   (req_op2),
    .req_ready_o (req_ready),
    .mul_en_o    (mul_en),
    .mul_op1_o   (mul_op1),
    .mul_op2_o   (mul_op2),
    .mul_res_i   (mul_res),
    .mul_ovf_i   (mul_ovf),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_ovf_o   (out_ovf),
    .out_ready_i (out_ready)
  );

  // Two-stage multiplier model; idle cycles emit junk that must be ignored.
  logic [2*DW-1:0] st1_res, st2_res;
  logic            st1_ovf, st2_ovf;
  always @(posedge clk) begin
    if (mul_en) begin
      st1_res <= {32'b0, mul_op1} * {32'b0, mul_op2};
      st1_ovf <= |(({32'b0, mul_op1} * {32'b0, mul_op2}) >> 32);
    end else begin
      st1_res <= {$urandom, $urandom};
      st1_ovf <= 1'b1;
    end
    st2_res <= st1_res;
    st2_ovf <= st1_ovf;
  end
  assign mul_res = st2_res;
  assign mul_ovf = st2_ovf;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  res_entry_t q[$];
  res_entry_t e;
  int accepts;
  int sent, rcvd, cyc;
  localparam int N_RAND = 400;

  initial begin
    rst = 1'b1; req_valid = 1'b1; req_op1 = 32'd1; req_op2 = 32'd1; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    // Reset state, with req_valid held high.
    chk("rst_out_valid", 65'(out_valid), 65'd0);
    chk("rst_req_ready", 65'(req_ready), 65'd0);
    chk("rst_mul_en",    65'(mul_en),    65'd0);
    rst = 1'b0; req_valid = 1'b0;
    #1;
    chk("post_rst_ready", 65'(req_ready), 65'd1);

    // Single op 3*5.
    tick();
    req_valid = 1'b1; req_op1 = 32'd3; req_op2 = 32'd5; out_ready = 1'b1;
    #1;
    chk("single_mul_en",  65'(mul_en),  65'd1);
    chk("single_mul_op1", 65'(mul_op1), 65'd3);
    chk("single_mul_op2", 65'(mul_op2), 65'd5);
    tick();                          // accept edge
    req_valid = 1'b0;
    #1; chk("single_lat1_valid", 65'(out_valid), 65'd0);
    tick(); #1; chk("single_lat2_valid", 65'(out_valid), 65'd0);
    tick(); #1;
    chk("single_valid", 65'(out_valid), 65'd1);
    chk("single_data",  65'(out_data),  65'd15);
    chk("single_ovf",   65'(out_ovf),   65'd0);
    tick(); #1; chk("single_drained", 65'(out_valid), 65'd0);

    // Back-to-back: overflowing product then 7*7.
    req_valid = 1'b1; req_op1 = 32'hFFFF_FFFF; req_op2 = 32'd2;
    #1; chk("b2b_first_en", 65'(mul_en), 65'd1);
    tick();
    req_op1 = 32'd7; req_op2 = 32'd7;
    #1; chk("b2b_second_en", 65'(mul_en), 65'd1);
    tick();
    req_valid = 1'b0;
    #1; chk("b2b_early_valid", 65'(out_valid), 65'd0);
    tick(); #1;
    chk("b2b_valid0", 65'(out_valid), 65'd1);
    chk("b2b_data0",  65'(out_data),  65'h1_FFFF_FFFE);
    chk("b2b_ovf0",   65'(out_ovf),   65'd1);
    tick(); #1;
    chk("b2b_valid1", 65'(out_valid), 65'd1);
    chk("b2b_data1",  65'(out_data),  65'd49);
    chk("b2b_ovf1",   65'(out_ovf),   65'd0);
    tick(); #1; chk("b2b_drained", 65'(out_valid), 65'd0);

    // Fill with out_ready=0 and req_valid held: exactly four accepts.
    out_ready = 1'b0;
    accepts = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_op1 = 32'(i + 1); req_op2 = 32'(i + 3);
      #1;
      chk($sformatf("fill_ready%0d", i), 65'(req_ready), 65'(i < 4));
      if (mul_en) accepts++;
      tick();
    end
    chk("fill_accepts",  65'(accepts),   65'd4);
    chk("fill_ready",    65'(req_ready), 65'd0);
    chk("fill_head",     65'(out_data),  65'd3);

    // One pop frees one slot, visible the cycle after.
    out_ready = 1'b1; req_valid = 1'b1; req_op1 = 32'd9; req_op2 = 32'd9;
    #1;
    chk("pop_ready_before", 65'(req_ready), 65'd0);
    chk("pop_head",         65'(out_data),  65'd3);
    tick();                          // pop edge
    out_ready = 1'b0;
    #1;
    chk("pop_ready_after", 65'(req_ready), 65'd1);
    chk("pop_accept",      65'(mul_en),    65'd1);
    tick();                          // accept edge
    req_valid = 1'b0;
    #1; chk("refill_ready", 65'(req_ready), 65'd0);
    tick(); tick();
    chk("full_ready", 65'(req_ready), 65'd0);
    out_ready = 1'b1;
    #1; chk("drain0", 65'(out_data), 65'd8);
    tick(); chk("drain1", 65'(out_data), 65'd15);
    tick(); chk("drain2", 65'(out_data), 65'd24);
    tick(); chk("drain3", 65'(out_data), 65'd81);
    tick(); chk("drain_empty", 65'(out_valid), 65'd0);

    // Reset with two buffered and two in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_op1 = 32'(i + 2); req_op2 = 32'(i + 2);
      #1; chk($sformatf("pre_rst_en%0d", i), 65'(mul_en), 65'd1);
      tick();
    end
    req_valid = 1'b0;
    #1; chk("pre_rst_valid", 65'(out_valid), 65'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 65'(out_valid), 65'd0);
    chk("mid_rst_ready", 65'(req_ready), 65'd0);
    tick(); tick();
    rst = 1'b0; out_ready = 1'b1;
    #1; chk("rel_ready", 65'(req_ready), 65'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("post_rst_empty%0d", i), 65'(out_valid), 65'd0);
    end

    // Throttled traffic against a scoreboard.
    sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < N_RAND && cyc < 20000) begin
      req_valid = (sent < N_RAND) && ($urandom_range(0, 3) != 0);
      req_op1   = $urandom;
      req_op2   = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rand_spurious", 65'(out_valid), 65'd0);
        end else begin
          e = q.pop_front();
          chk("rand_data", 65'(out_data), 65'(e.product));
          chk("rand_ovf",  65'(out_ovf),  65'(e.ovf));
          rcvd++;
        end
      end
      if (req_valid && req_ready) begin
        e.product = {32'b0, req_op1} * {32'b0, req_op2};
        e.ovf     = |e.product[63:32];
        q.push_back(e);
        sent++;
        chk("rand_occupancy", 65'(q.size() <= 4), 65'd1);
      end
      tick();
      cyc++;
    end
    chk("rand_received", 65'(rcvd), 65'(N_RAND));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mul_result_buffer
`default_nettype wire
